// File: rtl/fifo_row_skewer.sv
// Row skewer: pops packed activation rows from a show-ahead FIFO and feeds the
// systolic array west edge with lane i delayed by i cycles behind lane 0.
module fifo_row_skewer #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_ROWS  = 256,
  localparam int ROW_CNT_W = $clog2(MAX_ROWS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROW_CNT_W-1:0]   row_count,
  input  logic                   hold,
  input  logic                   fifo_empty,
  input  logic [LANES*WIDTH-1:0] fifo_read_data,
  output logic                   fifo_read_enable,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             fsm_state
);

  localparam int DRAIN_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [ROW_CNT_W-1:0] rows_left, rows_next;
  logic [DRAIN_W-1:0]   drain_cnt, drain_next;
  logic                 pop;

  // Handshake with the FIFO: fifo_read_data is the head row, valid whenever
  // fifo_empty is low; a row is consumed on every rising edge where
  // fifo_read_enable is high, and the strobe is never raised while empty.
  assign pop = (state == STREAM) && !hold && !fifo_empty && (rows_left != '0) && !rst;
  assign fifo_read_enable = pop;

  assign busy      = (state == STREAM) || (state == DRAIN);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rows_left <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      rows_left <= rows_next;
      drain_cnt <= drain_next;
    end
  end

  always_comb begin
    state_next = state;
    rows_next  = rows_left;
    drain_next = drain_cnt;
    unique case (state)
      IDLE: begin
        if (start && !hold) begin
          rows_next  = row_count;
          state_next = (row_count == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (pop) begin
          rows_next = rows_left - ROW_CNT_W'(1);
          if (rows_left == ROW_CNT_W'(1)) begin
            state_next = DRAIN;
            drain_next = DRAIN_W'(LANES - 1);
          end
        end
      end
      DRAIN: begin
        // Leaving as the count reaches zero puts DONE on the same cycle the
        // last row's final lane is presented.
        if (!hold) begin
          drain_next = drain_cnt - DRAIN_W'(1);
          if (drain_cnt == DRAIN_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] stage_data [i+1];
    logic             stage_valid [i+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          stage_data[j]  <= '0;
          stage_valid[j] <= 1'b0;
        end
      end else if (!hold) begin
        stage_data[0]  <= pop ? fifo_read_data[i*WIDTH +: WIDTH] : '0;
        stage_valid[0] <= pop;
        for (int j = 1; j <= i; j++) begin
          stage_data[j]  <= stage_data[j-1];
          stage_valid[j] <= stage_valid[j-1];
        end
      end
    end

    assign out_data[i*WIDTH +: WIDTH] = stage_data[i];
    assign out_valid[i]               = stage_valid[i];
  end

endmodule

// File: tb/tb_fifo_row_skewer.sv
// Bench for fifo_row_skewer: queue-based FIFO model plus a delay-line /
// tile-phase reference model compared against the DUT every cycle.
module tb_fifo_row_skewer;

  localparam int LANES    = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_ROWS = 256;
  localparam int RCW      = $clog2(MAX_ROWS + 1);
  localparam int ROW_W    = LANES * WIDTH;
  localparam int VEC_W    = 3 + LANES + ROW_W;

  localparam int P_IDLE = 0, P_STREAM = 1, P_WAIT = 2, P_DONE = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [RCW-1:0]   row_count;
  logic             hold;
  logic             fifo_empty;
  logic [ROW_W-1:0] fifo_read_data;
  logic             fifo_read_enable;
  logic [ROW_W-1:0] out_data;
  logic [LANES-1:0] out_valid;
  logic             busy;
  logic             done;
  logic [1:0]       fsm_state;

  fifo_row_skewer #(.LANES(LANES), .WIDTH(WIDTH), .MAX_ROWS(MAX_ROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .row_count(row_count), .hold(hold),
    .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_read_enable(fifo_read_enable), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ROW_W-1:0] fq[$];
  logic [ROW_W-1:0] hist_row[$];
  bit               hist_v[$];
  int               ph = P_IDLE;
  int               rows_left_m = 0;
  int               e_last = 0;

  logic [VEC_W-1:0] exp_vec, obs_vec;
  bit               chk;

  function automatic logic [ROW_W-1:0] rand_row();
    return ROW_W'($urandom());
  endfunction

  function automatic logic [WIDTH-1:0] lane_of(input logic [VEC_W-1:0] v, input int i);
    return v[i*WIDTH +: WIDTH];
  endfunction

  // One clock cycle: drive inputs, predict, sample at negedge, then advance
  // the FIFO and reference model after the rising edge.
  task automatic step(input bit st, input int rc, input bit hd, input bit rs);
    logic [ROW_W-1:0] head, tmp, ed;
    logic [LANES-1:0] ev;
    bit               ep;
    int               base;
    if (st) assert (rc <= MAX_ROWS) else $error("row_count above MAX_ROWS");
    start = st; row_count = RCW'(rc); hold = hd; rst = rs;
    head = (fq.size() != 0) ? fq[0] : '0;
    fifo_empty = (fq.size() == 0);
    fifo_read_data = head;
    ep = !rs && (ph == P_STREAM) && !hd && (fq.size() != 0);
    base = hist_row.size();
    for (int i = 0; i < LANES; i++) begin
      tmp = hist_row[base-1-i];
      ev[i] = hist_v[base-1-i];
      ed[i*WIDTH +: WIDTH] = tmp[i*WIDTH +: WIDTH];
    end
    exp_vec = {ep, (ph == P_STREAM) || (ph == P_WAIT), ph == P_DONE, ev, ed};
    chk = !rs;
    @(negedge clk);
    obs_vec = {fifo_read_enable, busy, done, out_valid, out_data};
    @(posedge clk);
    #1;
    if (obs_vec[VEC_W-1] && fq.size() != 0) void'(fq.pop_front());
    if (rs) begin
      ph = P_IDLE;
      for (int i = 0; i < LANES; i++) begin hist_row.push_back('0); hist_v.push_back(1'b0); end
    end else begin
      if (!hd) begin
        hist_row.push_back(ep ? head : '0);
        hist_v.push_back(ep);
      end
      case (ph)
        P_IDLE: if (st && !hd) begin
          if (rc == 0) ph = P_DONE;
          else begin rows_left_m = rc; ph = P_STREAM; end
        end
        P_STREAM: if (ep) begin
          rows_left_m--;
          if (rows_left_m == 0) begin ph = P_WAIT; e_last = base; end
        end
        P_DONE: ph = P_IDLE;
        default: ;
      endcase
      if (ph == P_WAIT && hist_row.size() == e_last + LANES) ph = P_DONE;
    end
  endtask

  task automatic test_reset();
    step(1, 3, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_checks++;
    if (obs_vec !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", obs_vec);
    end
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0);
      if (chk) begin
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
    end
  endtask

  task automatic test_basic();
    logic [VEC_W-1:0] seen [10];
    int done_at = -1;
    fq.push_back(32'h04030201);
    fq.push_back(32'h08070605);
    for (int c = 0; c < 10; c++) begin
      step(c == 0, 2, 0, 0);
      seen[c] = obs_vec;
      if (obs_vec[ROW_W+LANES] && done_at < 0) done_at = c;
      if (chk) begin
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL basic cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
    end
    n_checks++;
    if (done_at !== 6) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=6", done_at); end
    n_checks++;
    if (lane_of(seen[2], 0) !== 8'h01 || lane_of(seen[3], 0) !== 8'h05) begin
      n_fail++; $display("FAIL basic_lane0 got=%h,%h exp=01,05", lane_of(seen[2], 0), lane_of(seen[3], 0));
    end
    n_checks++;
    if (lane_of(seen[5], 3) !== 8'h04 || lane_of(seen[6], 3) !== 8'h08) begin
      n_fail++; $display("FAIL basic_lane3 got=%h,%h exp=04,08", lane_of(seen[5], 3), lane_of(seen[6], 3));
    end
    n_checks++;
    if (seen[1][VEC_W-2] !== 1'b1 || seen[5][VEC_W-2] !== 1'b1 || seen[6][VEC_W-2] !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy got=%b%b%b exp=110", seen[1][VEC_W-2], seen[5][VEC_W-2], seen[6][VEC_W-2]);
    end
  endtask

  task automatic test_underflow();
    int dones = 0;
    fq.push_back(rand_row());
    for (int c = 0; c < 25; c++) begin
      if (c == 5 || c == 9) fq.push_back(rand_row());
      step(c == 0, 3, 0, 0);
      if (obs_vec[ROW_W+LANES]) dones++;
      if (chk) begin
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL underflow cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL underflow_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_hold();
    logic [VEC_W-1:0] prev = '0;
    bit hd;
    for (int i = 0; i < 6; i++) fq.push_back(rand_row());
    for (int c = 0; c < 20; c++) begin
      hd = (c >= 3 && c <= 5);
      step(c == 0, 6, hd, 0);
      if (chk) begin
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL hold cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
      if (c == 4 || c == 5) begin
        n_checks++;
        if (obs_vec[ROW_W+LANES-1:0] !== prev[ROW_W+LANES-1:0] || obs_vec[VEC_W-1] !== 1'b0) begin
          n_fail++; $display("FAIL hold_frozen cyc=%0d got=%h exp=%h", c, obs_vec, prev);
        end
      end
      prev = obs_vec;
    end
  endtask

  task automatic test_zero_rows();
    int busy_seen = 0;
    int done_at = -1;
    for (int c = 0; c < 5; c++) begin
      step(c == 0, 0, 0, 0);
      if (obs_vec[VEC_W-2]) busy_seen++;
      if (obs_vec[ROW_W+LANES] && done_at < 0) done_at = c;
      if (chk) begin
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL zero_rows cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
    end
    n_checks++;
    if (busy_seen !== 0 || done_at !== 1) begin
      n_fail++; $display("FAIL zero_rows_summary got busy=%0d done_at=%0d exp busy=0 done_at=1", busy_seen, done_at);
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    for (int i = 0; i < 8; i++) fq.push_back(rand_row());
    for (int c = 0; c < 16; c++) begin
      step(c == 0 || c == 2, (c == 2) ? 7 : 5, 0, 0);
      if (obs_vec[ROW_W+LANES]) dones++;
      if (chk) begin
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL start_busy cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
    end
    n_checks++;
    if (dones !== 1 || fq.size() !== 3) begin
      n_fail++; $display("FAIL start_busy_summary got dones=%0d left=%0d exp dones=1 left=3", dones, fq.size());
    end
    fq.delete();
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    int done_at = -1;
    for (int i = 0; i < 4; i++) fq.push_back(rand_row());
    for (int c = 0; c < 15; c++) begin
      step(c == 0 || c == 6, (c == 6) ? 1 : 4, 0, c == 4);
      if (obs_vec[ROW_W+LANES] && c != 4) begin dones++; if (done_at < 0) done_at = c; end
      if (c == 4) begin
        n_checks++;
        if (obs_vec[ROW_W+2:ROW_W] !== 3'b111) begin n_fail++; $display("FAIL mid_reset_pre got=%b exp=111", obs_vec[ROW_W+2:ROW_W]); end
      end
      if (c == 5) begin
        n_checks++;
        if (obs_vec !== '0) begin n_fail++; $display("FAIL mid_reset_clear got=%h exp=0", obs_vec); end
      end
      if (chk) begin
        n_checks++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL mid_reset cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); end
      end
    end
    n_checks++;
    if (dones !== 1 || done_at !== 11) begin
      n_fail++; $display("FAIL mid_reset_done got dones=%0d at=%0d exp dones=1 at=11", dones, done_at);
    end
    fq.delete();
  endtask

  task automatic test_random_tiles();
    int rc, pushed;
    for (int t = 0; t < 10; t++) begin
      rc = $urandom_range(1, 6);
      pushed = 0;
      for (int c = 0; c < 60; c++) begin
        if (pushed < rc && $urandom_range(0, 1) == 1) begin fq.push_back(rand_row()); pushed++; end
        step(c == 0, rc, c != 0 && $urandom_range(0, 3) == 0, 0);
        if (chk) begin
          n_checks++;
          if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random tile=%0d cyc=%0d got=%h exp=%h", t, c, obs_vec, exp_vec); end
        end
      end
      step(0, 0, 0, 0);
      n_checks++;
      if (obs_vec[VEC_W-2] !== 1'b0) begin n_fail++; $display("FAIL random_timeout tile=%0d busy=%b exp=0", t, obs_vec[VEC_W-2]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; row_count = '0; hold = 1'b0;
    fifo_empty = 1'b1; fifo_read_data = '0;
    for (int i = 0; i < LANES; i++) begin hist_row.push_back('0); hist_v.push_back(1'b0); end
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_underflow();
    test_hold();
    test_zero_rows();
    test_start_while_busy();
    test_mid_reset();
    test_random_tiles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
